// File: rtl/doy_to_date.sv
// doy_to_date
//   Converts a 1-based day-of-year into (month, day_of_month) by walking the
//   month-length table one month per cycle, subtracting each length from a
//   running remainder until the remainder fits inside the current month.
//
//   Build option: define SYMMETRY_CAL_EN to add the Symmetry calendar
//   (28/35/28 per quarter, leap Dec = 35). Without it, cal_sel is ignored and
//   only the Gregorian table exists.
//
//   Ports
//     clk          in   sole clock, rising edge
//     rst          in   synchronous active-high reset
//     start        in   request, sampled only while idle
//     day_of_year  in   9-bit day of year, 1-based
//     cal_sel      in   0 = Gregorian, 1 = Symmetry
//     leap         in   leap-year flag for the selected calendar
//     busy         out  high while running and during the done cycle
//     done         out  one-cycle completion pulse
//     error        out  day_of_year out of range, valid with done
//     month        out  result month 1..12 (0 on error)
//     day_of_month out  result day 1..35 (0 on error)
//     state_dbg    out  current FSM state (0 IDLE, 1 RUN, 2 DONE)
//
//   Handshake: a request is accepted on a rising edge where start=1 and the
//   block is idle (busy=0). Inputs are latched at that edge; later changes
//   are ignored. Exactly one done pulse follows each accepted request unless
//   rst intervenes. Results hold until the next accepted request or reset.

module doy_to_date (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [8:0] day_of_year,
  input  logic       cal_sel,
  input  logic       leap,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [3:0] month,
  output logic [5:0] day_of_month,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_q;
  logic [8:0] rem_q;
  logic [3:0] idx_q;
  logic       leap_q;
  logic       busy_q;
  logic       done_q;
  logic       err_q;
  logic [3:0] month_q;
  logic [5:0] dom_q;

  // Gregorian month length for a 1-based month index.
  function automatic logic [5:0] greg_len(input logic [3:0] m, input logic lp);
    logic [5:0] l;
    case (m)
      4'd2:                      l = lp ? 6'd29 : 6'd28;
      4'd4, 4'd6, 4'd9, 4'd11:   l = 6'd30;
      default:                   l = 6'd31;
    endcase
    return l;
  endfunction

`ifdef SYMMETRY_CAL_EN
  logic cal_q;

  // Symmetry month length: the middle month of each quarter is 35 days,
  // the others 28; a leap year stretches December to 35.
  function automatic logic [5:0] sym_len(input logic [3:0] m, input logic lp);
    logic [5:0] l;
    case (m)
      4'd2, 4'd5, 4'd8, 4'd11: l = 6'd35;
      4'd12:                   l = lp ? 6'd35 : 6'd28;
      default:                 l = 6'd28;
    endcase
    return l;
  endfunction
`else
  // Calendar select has no effect in a Gregorian-only build.
  logic unused_cal_sel;
  assign unused_cal_sel = cal_sel;
`endif

  // Year length of the request being presented (used for the range check)
  // and length of the month currently being examined in RUN.
  logic [8:0] year_len;
  logic [5:0] cur_len;
  logic [8:0] rem_d;
  logic       fits;
  logic       doy_bad;

  always_comb begin
    year_len = leap ? 9'd366 : 9'd365;
    cur_len  = greg_len(idx_q, leap_q);
`ifdef SYMMETRY_CAL_EN
    if (cal_sel) begin
      year_len = leap ? 9'd371 : 9'd364;
    end
    if (cal_q) begin
      cur_len = sym_len(idx_q, leap_q);
    end
`endif
    fits    = (rem_q <= {3'b000, cur_len});
    // Only taken when the remainder exceeds the month length, so no underflow.
    rem_d   = rem_q - {3'b000, cur_len};
    doy_bad = (day_of_year == 9'd0) || (day_of_year > year_len);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= 9'd0;
      idx_q   <= 4'd0;
      leap_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      month_q <= 4'd0;
      dom_q   <= 6'd0;
`ifdef SYMMETRY_CAL_EN
      cal_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          if (start) begin
            leap_q  <= leap;
`ifdef SYMMETRY_CAL_EN
            cal_q   <= cal_sel;
`endif
            busy_q  <= 1'b1;
            month_q <= 4'd0;
            dom_q   <= 6'd0;
            if (doy_bad) begin
              // Out of range: report immediately without walking the table.
              state_q <= DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              state_q <= RUN;
              err_q   <= 1'b0;
              rem_q   <= day_of_year;
              idx_q   <= 4'd1;
            end
          end
        end

        RUN: begin
          // The range check guarantees fits is true by month 12.
          if (fits) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            err_q   <= 1'b0;
            month_q <= idx_q;
            dom_q   <= rem_q[5:0];
          end else begin
            rem_q <= rem_d;
            idx_q <= idx_q + 4'd1;
          end
        end

        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = err_q;
  assign month        = month_q;
  assign day_of_month = dom_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_doy_to_date.sv
// Testbench for doy_to_date: directed cases plus randomized requests, checked
// by a scoreboard fed from a calendar reference model.
module tb_doy_to_date;

  localparam int W = 11;  // {error, month[3:0], day_of_month[5:0]}

`ifdef SYMMETRY_CAL_EN
  localparam bit SYM_EN = 1'b1;
`else
  localparam bit SYM_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [8:0] day_of_year = 9'd0;
  logic       cal_sel = 1'b0;
  logic       leap = 1'b0;
  logic       busy;
  logic       done;
  logic       error;
  logic [3:0] month;
  logic [5:0] day_of_month;
  logic [1:0] state_dbg;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic done_prev = 1'b0;

  logic [W-1:0] exp_q[$];
  int           lat_q[$];
  int           acc_q[$];

  doy_to_date dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .day_of_year  (day_of_year),
    .cal_sel      (cal_sel),
    .leap         (leap),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .month        (month),
    .day_of_month (day_of_month),
    .state_dbg    (state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- helpers ----------------
  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: builds the month table from the calendar rules and
  // walks it with plain arithmetic. Returns {error, month, day}; lat is the
  // number of cycles from the accepting edge to done.
  function automatic logic [W-1:0] ref_model(input int d, input logic c,
                                             input logic l, output int lat);
    int   greg[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    int   len[12];
    int   total;
    int   r;
    logic sym;
    sym   = c & SYM_EN;
    total = 0;
    for (int m = 0; m < 12; m++) begin
      len[m] = sym ? ((m % 3 == 1) ? 35 : 28) : greg[m];
    end
    if (l) begin
      if (sym) len[11] = 35;
      else     len[1]  = 29;
    end
    for (int m = 0; m < 12; m++) total += len[m];
    lat = 1;
    if (d < 1 || d > total) return {1'b1, 4'd0, 6'd0};
    r = d;
    for (int m = 0; m < 12; m++) begin
      if (r <= len[m]) begin
        lat = m + 2;
        return {1'b0, 4'(m + 1), 6'(r)};
      end
      r -= len[m];
    end
    return '0;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    int           lat;
    int           acc;
    if (!rst) begin
      if (done && done_prev) begin
        checks++;
        errors++;
        $display("FAIL done_width: done high two cycles in a row (cycle %0d)", cyc);
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got month %0d day %0d err %0b with nothing pending",
                   month, day_of_month, error);
        end else begin
          e   = exp_q.pop_front();
          lat = lat_q.pop_front();
          acc = acc_q.pop_front();
          chk("result_error", int'(error), int'(e[10]));
          chk("result_month", int'(month), int'(e[9:6]));
          chk("result_day", int'(day_of_month), int'(e[5:0]));
          chk("latency", cyc - acc + 1, lat);
          chk("busy_with_done", int'(busy), 1);
        end
      end
    end
    done_prev = done;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", int'(busy), 0);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("done_timeout", exp_q.size(), 0);
    if (exp_q.size() != 0) begin
      exp_q.delete();
      lat_q.delete();
      acc_q.delete();
    end
  endtask

  // Issue one request; optionally poke a second start while busy, which
  // must be ignored. Inputs are scrambled after latching.
  task automatic run_op(input logic [8:0] d, input logic c, input logic l,
                        input bit poke);
    int lat;
    logic [W-1:0] e;
    wait_idle();
    day_of_year = d;
    cal_sel     = c;
    leap        = l;
    start       = 1'b1;
    e = ref_model(int'(d), c, l, lat);
    exp_q.push_back(e);
    lat_q.push_back(lat);
    acc_q.push_back(cyc + 1);
    @(negedge clk);
    start       = 1'b0;
    day_of_year = 9'($urandom_range(0, 511));
    cal_sel     = 1'($urandom_range(0, 1));
    leap        = 1'($urandom_range(0, 1));
    chk("busy_after_start", int'(busy), 1);
    if (poke && busy) begin
      day_of_year = 9'd5;
      start       = 1'b1;
      @(negedge clk);
      start       = 1'b0;
    end
    wait_drain();
  endtask

  task automatic check_hold(input logic [8:0] d, input logic c, input logic l);
    int lat;
    logic [W-1:0] e;
    e = ref_model(int'(d), c, l, lat);
    repeat (3) @(negedge clk);
    chk("hold_error", int'(error), int'(e[10]));
    chk("hold_month", int'(month), int'(e[9:6]));
    chk("hold_day", int'(day_of_month), int'(e[5:0]));
    chk("hold_done_low", int'(done), 0);
  endtask

  // ---------------- stimulus ----------------
  typedef struct {
    logic [8:0] d;
    logic       c;
    logic       l;
  } vec_t;

  vec_t dir[] = '{
    '{9'd1,   1'b0, 1'b0}, '{9'd60,  1'b0, 1'b1}, '{9'd60,  1'b0, 1'b0},
    '{9'd365, 1'b0, 1'b0}, '{9'd366, 1'b0, 1'b0}, '{9'd0,   1'b0, 1'b0},
    '{9'd366, 1'b0, 1'b1}, '{9'd367, 1'b0, 1'b1}, '{9'd511, 1'b0, 1'b0},
    '{9'd91,  1'b1, 1'b0}, '{9'd92,  1'b1, 1'b0}, '{9'd371, 1'b1, 1'b1},
    '{9'd371, 1'b1, 1'b0}, '{9'd364, 1'b1, 1'b0}, '{9'd365, 1'b1, 1'b0},
    '{9'd0,   1'b1, 1'b1}, '{9'd300, 1'b0, 1'b0}
  };

  initial begin
    // reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_error", int'(error), 0);
    chk("rst_month", int'(month), 0);
    chk("rst_day", int'(day_of_month), 0);
    chk("rst_state", int'(state_dbg), 0);
    rst = 1'b0;
    @(negedge clk);

    // directed cases, each followed by a hold check
    foreach (dir[i]) begin
      run_op(dir[i].d, dir[i].c, dir[i].l, 1'b0);
      check_hold(dir[i].d, dir[i].c, dir[i].l);
    end

    // second start during RUN is ignored: 300 -> Oct 27
    run_op(9'd300, 1'b0, 1'b0, 1'b1);
    check_hold(9'd300, 1'b0, 1'b0);

    // reset in the 4th RUN cycle aborts without a done pulse
    wait_idle();
    day_of_year = 9'd300;
    cal_sel     = 1'b0;
    leap        = 1'b0;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_month", int'(month), 0);
    chk("abort_day", int'(day_of_month), 0);
    chk("abort_state", int'(state_dbg), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_no_done", int'(done), 0);
    run_op(9'd45, 1'b0, 1'b0, 1'b0);

    // randomized back-to-back requests
    for (int i = 0; i < 150; i++) begin
      logic [8:0] d;
      d = ($urandom_range(0, 9) == 0) ? 9'($urandom_range(0, 511))
                                      : 9'($urandom_range(0, 372));
      run_op(d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             bit'($urandom_range(0, 3) == 0));
    end

    repeat (3) @(negedge clk);
    chk("final_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/doy_to_date.md
DOY_TO_DATE -- requirements
Module: doy_to_date

Interface
REQ-001 Parameters: none.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 start  in  1  request; sampled only in IDLE.
REQ-005 day_of_year  in  9  day of year, 1-based.
REQ-006 cal_sel  in  1  calendar select: 0 = Gregorian, 1 = Symmetry.
REQ-007 leap  in  1  leap-year flag for the selected calendar.
REQ-008 busy  out  1  high in RUN and DONE.
REQ-009 done  out  1  one-cycle completion pulse.
REQ-010 error  out  1  out-of-range day_of_year, valid with done.
REQ-011 month  out  4  result month, 1..12.
REQ-012 day_of_month  out  6  result day, 1..35.

Function
REQ-013 Month lengths SHALL be constants:
- Gregorian: 31,28,31,30,31,30,31,31,30,31,30,31; leap Feb = 29.
- Symmetry: 28,35,28 repeated per quarter; leap Dec = 35.
REQ-014 Year length SHALL be:
- Gregorian: 365 (366 if leap).
- Symmetry: 364 (371 if leap).
REQ-015 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-016 In IDLE, start=1 SHALL latch day_of_year, cal_sel and leap, then range-check the latched value:
- 0 or greater than year length: go to DONE with error=1, month=0, day_of_month=0.
- Otherwise: go to RUN with remainder = day_of_year and month index = 1.
REQ-017 Each RUN cycle SHALL compare remainder against the length of the current month index:
- remainder <= length: load month and day_of_month = remainder, error=0, go to DONE.
- Otherwise: subtract the length from remainder, increment the index, stay in RUN.
REQ-018 Latency SHALL be counted from the edge that samples start to the first cycle with done=1:
- Valid result in month M: M+1 cycles.
- Error: 1 cycle.
REQ-019 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-020 month, day_of_month and error SHALL hold their values until the next accepted start or reset.
REQ-021 start SHALL be ignored while busy=1; input changes after latching SHALL NOT affect the result.
REQ-022 The range check SHALL guarantee termination by month index 12.
REQ-023 The remainder register SHALL be 9 bits; subtraction SHALL never underflow.
REQ-024 start asserted in the cycle after done SHALL be accepted, since the FSM is then in IDLE.

Reset
REQ-025 rst=1 SHALL force IDLE and clear busy, done, error, month, day_of_month and remainder on the next edge.
REQ-026 Reset during RUN or DONE SHALL abort the operation with no done pulse; rst SHALL take priority over start.

Configuration
REQ-027 Macro SYMMETRY_CAL_EN SHALL control Symmetry calendar support:
- Defined: cal_sel selects the calendar per REQ-013/014.
- Undefined: cal_sel is ignored, Gregorian tables only, and no Symmetry table logic is synthesized.

Verification
REQ-028 Gregorian, leap=0, day_of_year=1 -> month=1, day_of_month=1, error=0; done 2 cycles after start.
REQ-029 Gregorian day_of_year=60:
- leap=1 -> month=2, day_of_month=29, latency 3.
- leap=0 -> month=3, day_of_month=1, latency 4.
REQ-030 Gregorian, leap=0:
- day_of_year=365 -> month=12, day_of_month=31, latency 13.
- day_of_year=366 -> error=1, month=0, latency 1.
- day_of_year=0 -> error=1.
REQ-031 Symmetry (SYMMETRY_CAL_EN defined):
- leap=0, day_of_year=91 -> month=3, day_of_month=28.
- leap=0, day_of_year=92 -> month=4, day_of_month=1.
- leap=1, day_of_year=371 -> month=12, day_of_month=35.
- leap=0, day_of_year=371 -> error=1.
REQ-032 Start with day_of_year=300; pulse start again with day_of_year=5 during RUN -> second start ignored, result month=10, day_of_month=27.
REQ-033 Assert rst in the 4th RUN cycle -> next cycle busy=0, month=0, day_of_month=0, no done pulse; a subsequent start completes normally.
